alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
Parametrised, handshaked ALU: WIDTH-bit operands, 4-bit opcode, registered result plus status flags. Successor to the fixed 16-bit combinational ALU. Adds valid/ready flow control, rotate/arithmetic-shift ops, status flags and an optional iterative multiplier. Sits between the operand register file and the writeback stage of the lab datapath.

Parameters:
WIDTH, 16, operand/result width; power of two, 8..64
SHW, $clog2(WIDTH), derived shift-amount width; not overridden

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand/opcode valid
in_ready  out  1  block can accept an operation this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
sel  in  4  opcode
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts the result
result  out  WIDTH  registered result
flags  out  4  {ovf, neg, carry, zero}, registered with result
busy  out  1  high while a multiply is in progress

Behaviour:
- Opcodes: 0 ADD; 1 SUB (A-B); 2 AND; 3 OR; 4 XOR; 5 SHL; 6 SHR (logical); 7 CMP; 8 ROL; 9 ROR; 10 SRA; 11 MUL (low WIDTH bits of A*B); 12-15 invalid.
- Shift/rotate amount = b[SHW-1:0], i.e. B mod WIDTH. Amount 0 returns A unchanged.
- CMP is unsigned: 0 if A==B, 1 if A>B, 2 if A<B, zero-extended to WIDTH.
- Invalid opcodes: result 0, flags 4'b0001, latency 1.
- Flags:
  - zero = (result==0); neg = result[WIDTH-1].
  - carry = carry-out for ADD, borrow (A<B unsigned) for SUB, 0 otherwise.
  - ovf = signed overflow for ADD/SUB, 0 otherwise.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - MUL: in_ready=0, busy=1, one shift-add iteration per cycle, counter 0..WIDTH-1.
  - DONE: out_valid=1, in_ready=out_ready.
- Accept occurs when in_valid && in_ready at a rising edge.
- Single-cycle op accepted: result/flags written on the accept edge; DONE next cycle (latency 1).
- MUL accepted: operands latched, enter MUL. Result is written and DONE entered on the WIDTH-th edge after the accept edge.
- DONE with out_ready=1: result consumed at the edge.
  - If a new op is accepted on the same edge, go to DONE (single-cycle op) or MUL. Full throughput of 1 op/cycle for non-MUL ops.
  - Otherwise go to IDLE.
- DONE with out_ready=0: result, flags and out_valid held stable; in_ready=0; inputs ignored.
- in_valid while in MUL is ignored (in_ready=0); upstream must hold.
- Reset, asynchronous and at any time including mid-MUL: state IDLE, out_valid=0, busy=0, result=0, flags=0, counter=0. In-flight operation is discarded.
- All arithmetic is modulo 2^WIDTH. There are no combinational paths from inputs to result/flags/out_valid.
- in_ready depends combinationally on out_ready in DONE only.

Optional Feature:
ALU_MUL_EN
- Defined: opcode 11 performs the iterative multiply as above; busy port is functional.
- Undefined: multiplier logic and MUL state removed. Opcode 11 is treated as an invalid opcode (result 0, flags 4'b0001, latency 1). busy is tied 0.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams/enum (OP_ADD..OP_MUL), width 4
  - flag bit indices (FLG_ZERO=0, FLG_CARRY=1, FLG_NEG=2, FLG_OVF=3)
  - FSM state enum (S_IDLE, S_MUL, S_DONE)
- One sub-module, alu_mul_seq: iterative shift-add multiplier with start/done, WIDTH-cycle latency. Instantiated only under ALU_MUL_EN.
- Combinational op decode stays in alu_pipe.

Test Plan:
1. WIDTH=16, ADD a=0xFFFF b=0x0001 -> result 0x0000, flags 4'b0011, out_valid one cycle after accept. Then SUB a=0x7FFF b=0xFFFF -> 0x8000, flags 4'b1110.
2. SHL a=0x0001 b=0x0013 -> 0x0008. ROR a=0x0001 b=1 -> 0x8000. SRA a=0x8000 b=4 -> 0xF800. ROL a=0x8001 b=0 -> 0x8001.
3. CMP: a=5,b=9 -> 0x0002; a=9,b=5 -> 0x0001; a=b=7 -> 0x0000 with zero=1. Sel=13 -> 0x0000, flags 4'b0001.
4. MUL a=0x0123 b=0x0045 with ALU_MUL_EN -> 0x4E6F. out_valid after the 16th edge post-accept; busy=1 and in_ready=0 throughout. Without the macro: 0x0000, flags 4'b0001, latency 1.
5. Backpressure: out_ready=0 for 5 cycles -> result/flags stable, in_ready=0. Then out_ready=1 with in_valid=1 ADD 2+3 on the same edge -> next result 0x0005 the following cycle, no bubble. Streaming 10 ADDs with out_ready=1 -> 10 results in 10 consecutive cycles.
6. Assert rst asynchronously mid-MUL (cycle 7) -> out_valid=0, busy=0, result=0, flags=0 immediately. After release, in_ready=1 and a new ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode, flag-index and FSM state constants shared by the alu_pipe block
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8;
  localparam logic [3:0] OP_ROR = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_NEG   = 2;
  localparam int FLG_OVF   = 3;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/opcode input handshake, result/flags output handshake and busy; master = upstream/consumer side, slave = ALU side
interface alu_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             busy;
  modport master (output in_valid, a, b, sel, out_ready, input in_ready, out_valid, result, flags, busy);
  modport slave  (input in_valid, a, b, sel, out_ready, output in_ready, out_valid, result, flags, busy);
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier (low WIDTH bits); start latches a/b, done is high on the cycle whose edge completes the WIDTH-th iteration with the product on p
module alu_mul_seq #(
  parameter int WIDTH = 16,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] p
);
  logic             run;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, ma, mb;
  assign p    = acc + (mb[0] ? ma : '0);
  assign done = run && cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
      acc <= '0;
      ma  <= '0;
      mb  <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= '0;
      acc <= '0;
      ma  <= a;
      mb  <= b;
    end else if (run) begin
      acc <= p;
      ma  <= ma << 1;
      mb  <= mb >> 1;
      cnt <= done ? '0 : cnt + 1'b1;
      run <= !done;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result and {ovf,neg,carry,zero} flags; ports clk, rst (async high), bus (alu_pipe_if.slave); `define ALU_MUL_EN enables the iterative multiply (opcode 11) and busy
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  alu_pipe_if.slave bus
);
  logic [1:0]         state;
  logic [WIDTH-1:0]   result;
  logic [3:0]         flags;
  logic               accept, is_mul, mul_done;
  logic [WIDTH-1:0]   mul_p;
  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     sum, dif;
  logic [2*WIDTH-1:0] rl, rr;
  logic [WIDTH-1:0]   sra, cmp, res;
  logic               carry, ovf;
  logic [3:0]         flg;
  assign bus.in_ready  = state == S_IDLE || (state == S_DONE && bus.out_ready);
  assign bus.out_valid = state == S_DONE;
  assign bus.busy      = state == S_MUL;
  assign bus.result    = result;
  assign bus.flags     = flags;
  assign accept        = bus.in_valid && bus.in_ready;
  assign sh            = bus.b[SHW-1:0];
`ifdef ALU_MUL_EN
  assign is_mul = bus.sel == OP_MUL;
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(accept && is_mul),
    .a(bus.a),
    .b(bus.b),
    .done(mul_done),
    .p(mul_p)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_p    = '0;
`endif
  always_comb begin
    sum   = {1'b0, bus.a} + {1'b0, bus.b};
    dif   = {1'b0, bus.a} - {1'b0, bus.b};
    rl    = {bus.a, bus.a} << sh;
    rr    = {bus.a, bus.a} >> sh;
    sra   = $signed(bus.a) >>> sh;
    cmp   = bus.a == bus.b ? '0 : bus.a > bus.b ? WIDTH'(1) : WIDTH'(2);
    res   = bus.sel == OP_ADD ? sum[WIDTH-1:0] :
            bus.sel == OP_SUB ? dif[WIDTH-1:0] :
            bus.sel == OP_AND ? bus.a & bus.b :
            bus.sel == OP_OR  ? bus.a | bus.b :
            bus.sel == OP_XOR ? bus.a ^ bus.b :
            bus.sel == OP_SHL ? bus.a << sh :
            bus.sel == OP_SHR ? bus.a >> sh :
            bus.sel == OP_CMP ? cmp :
            bus.sel == OP_ROL ? rl[2*WIDTH-1:WIDTH] :
            bus.sel == OP_ROR ? rr[WIDTH-1:0] :
            bus.sel == OP_SRA ? sra : '0;
    carry = bus.sel == OP_ADD ? sum[WIDTH] : bus.sel == OP_SUB ? dif[WIDTH] : 1'b0;
    ovf   = bus.sel == OP_ADD ? (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]) :
            bus.sel == OP_SUB ? (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]) : 1'b0;
    flg   = '0;
    flg[FLG_ZERO]  = res == '0;
    flg[FLG_CARRY] = carry;
    flg[FLG_NEG]   = res[WIDTH-1];
    flg[FLG_OVF]   = ovf;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      result <= '0;
      flags  <= '0;
    end else if (accept) begin
      state <= is_mul ? S_MUL : S_DONE;
      if (!is_mul) begin
        result <= res;
        flags  <= flg;
      end
    end else if (state == S_MUL && mul_done) begin
      state  <= S_DONE;
      result <= mul_p;
      flags  <= {1'b0, mul_p[WIDTH-1], 1'b0, mul_p == '0};
    end else if (state == S_DONE && bus.out_ready) begin
      state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe (WIDTH=16), builds with or without ALU_MUL_EN
module tb_alu_pipe;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_chk = 0;
  alu_pipe_if #(.WIDTH(16)) bus ();
  alu_pipe #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic op1(input string tag, input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                     input logic [15:0] er, input logic [3:0] ef);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.sel = s;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, "_valid"}, 16'(bus.out_valid), 16'd1);
    chk({tag, "_res"}, bus.result, er);
    chk({tag, "_flg"}, 16'(bus.flags), 16'(ef));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sel = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_res", bus.result, 16'h0000);
    chk("rst_flg", 16'(bus.flags), 16'h0);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_ready", 16'(bus.in_ready), 16'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    op1("add", 16'hFFFF, 16'h0001, OP_ADD, 16'h0000, 4'b0011);
    op1("sub", 16'h7FFF, 16'hFFFF, OP_SUB, 16'h8000, 4'b1110);
    op1("shl", 16'h0001, 16'h0013, OP_SHL, 16'h0008, 4'b0000);
    op1("ror", 16'h0001, 16'h0001, OP_ROR, 16'h8000, 4'b0100);
    op1("sra", 16'h8000, 16'h0004, OP_SRA, 16'hF800, 4'b0100);
    op1("rol0", 16'h8001, 16'h0000, OP_ROL, 16'h8001, 4'b0100);
    op1("shr", 16'hF000, 16'h0014, OP_SHR, 16'h0F00, 4'b0000);
    op1("xor", 16'hFF00, 16'h0FF0, OP_XOR, 16'hF0F0, 4'b0100);
    op1("cmp_lt", 16'd5, 16'd9, OP_CMP, 16'h0002, 4'b0000);
    op1("cmp_gt", 16'd9, 16'd5, OP_CMP, 16'h0001, 4'b0000);
    op1("cmp_eq", 16'd7, 16'd7, OP_CMP, 16'h0000, 4'b0001);
    op1("inv13", 16'h1234, 16'h5678, 4'd13, 16'h0000, 4'b0001);
`ifdef ALU_MUL_EN
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 16'h0123;
    bus.b = 16'h0045;
    bus.sel = OP_MUL;
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("mul_busy%0d", i), 16'(bus.busy), 16'd1);
      chk($sformatf("mul_rdy%0d", i), 16'(bus.in_ready), 16'd0);
      chk($sformatf("mul_nv%0d", i), 16'(bus.out_valid), 16'd0);
    end
    @(negedge clk);
    chk("mul_valid", 16'(bus.out_valid), 16'd1);
    chk("mul_res", bus.result, 16'h4E6F);
    chk("mul_flg", 16'(bus.flags), 16'h0);
    chk("mul_busy_end", 16'(bus.busy), 16'd0);
`else
    op1("mul_off", 16'h0123, 16'h0045, OP_MUL, 16'h0000, 4'b0001);
    chk("mul_off_busy", 16'(bus.busy), 16'd0);
`endif
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = 16'd1;
    bus.b = 16'd1;
    bus.sel = OP_ADD;
    @(posedge clk);
    @(negedge clk);
    bus.a = 16'd2;
    bus.b = 16'd3;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid%0d", i), 16'(bus.out_valid), 16'd1);
      chk($sformatf("bp_res%0d", i), bus.result, 16'd2);
      chk($sformatf("bp_flg%0d", i), 16'(bus.flags), 16'h0);
      chk($sformatf("bp_rdy%0d", i), 16'(bus.in_ready), 16'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rdy_release", 16'(bus.in_ready), 16'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_next_valid", 16'(bus.out_valid), 16'd1);
    chk("bp_next_res", bus.result, 16'h0005);
    for (int i = 0; i < 10; i++) begin
      bus.a = 16'(i * 3);
      bus.b = 16'd100;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("str_valid%0d", i), 16'(bus.out_valid), 16'd1);
      chk($sformatf("str_res%0d", i), bus.result, 16'(i * 3 + 100));
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("str_idle", 16'(bus.out_valid), 16'd0);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
`ifdef ALU_MUL_EN
    bus.a = 16'h0123;
    bus.b = 16'h0045;
    bus.sel = OP_MUL;
`else
    bus.a = 16'd3;
    bus.b = 16'd4;
    bus.sel = OP_ADD;
`endif
    @(posedge clk);
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 16'(bus.out_valid), 16'd0);
    chk("arst_busy", 16'(bus.busy), 16'd0);
    chk("arst_res", bus.result, 16'h0000);
    chk("arst_flg", 16'(bus.flags), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("arst_ready", 16'(bus.in_ready), 16'd1);
    op1("post_add", 16'h1234, 16'h1111, OP_ADD, 16'h2345, 4'b0000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
